// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - N/V/Z flag register, pending-write tracker and branch resolver
// Optional FLAG_BYPASS_EN: resolve one cycle early on the last outstanding flag write.
module branch_resolve_unit #(
   parameter int PEND_W = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  flag_in,
   input  logic        flag_we_nv,
   input  logic        flag_we_z,
   input  logic        pend_inc,
   output logic        pend_full,
   output logic        pend_err,
   output logic [2:0]  flags_out,
   input  logic        br_valid,
   output logic        br_ready,
   input  logic [2:0]  br_ccc,
   input  logic [15:0] br_pc,
   input  logic [8:0]  br_imm,
   input  logic        br_reg_sel,
   input  logic [15:0] br_reg_val,
   output logic        res_valid,
   output logic        res_taken,
   output logic [15:0] res_target
);

   localparam logic [PEND_W-1:0] PEND_MAX = '1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t            state;
   logic [PEND_W-1:0] pend_cnt;
   logic [2:0]        flags_q;
   logic [2:0]        ccc_q;
   logic [15:0]       pc_q;
   logic [8:0]        imm_q;
   logic              sel_q;
   logic [15:0]       rv_q;

   logic              flag_wr;
   logic              resolve;
   logic [2:0]        eval_flags;
   logic [15:0]       seq_pc;
   logic [15:0]       imm_target;
   logic              taken_now;

   assign flag_wr   = flag_we_nv | flag_we_z;
   assign pend_full = (pend_cnt == PEND_MAX);
   assign flags_out = flags_q;

`ifdef FLAG_BYPASS_EN
   logic [2:0] flags_merged;
   assign flags_merged = {flag_we_nv ? flag_in[2:1] : flags_q[2:1],
                          flag_we_z  ? flag_in[0]   : flags_q[0]};
   // The single outstanding writer retiring this cycle makes its flags final now.
   assign resolve    = (pend_cnt == '0) ||
                       ((pend_cnt == PEND_W'(1)) && flag_wr && !pend_inc);
   assign eval_flags = flags_merged;
`else
   assign resolve    = (pend_cnt == '0);
   assign eval_flags = flags_q;
`endif

   function automatic logic cond_true(input logic [2:0] ccc, input logic [2:0] f);
      logic n, v, z;
      n = f[2];
      v = f[1];
      z = f[0];
      case (ccc)
         3'b000:  cond_true = !z;
         3'b001:  cond_true = z;
         3'b010:  cond_true = !z && !n;
         3'b011:  cond_true = n;
         3'b100:  cond_true = !n || z;
         3'b101:  cond_true = n || z;
         3'b110:  cond_true = v;
         default: cond_true = 1'b1;
      endcase
   endfunction

   assign seq_pc     = pc_q + 16'd2;
   assign imm_target = seq_pc + {{6{imm_q[8]}}, imm_q, 1'b0};
   assign taken_now  = cond_true(ccc_q, eval_flags);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_cnt <= '0;
         pend_err <= 1'b0;
         flags_q  <= 3'b000;
      end else begin
         if (flag_we_nv) flags_q[2:1] <= flag_in[2:1];
         if (flag_we_z)  flags_q[0]   <= flag_in[0];
         case ({pend_inc, flag_wr})
            2'b10: begin
               if (pend_cnt == PEND_MAX) pend_err <= 1'b1;
               else                      pend_cnt <= pend_cnt + PEND_W'(1);
            end
            2'b01: begin
               if (pend_cnt == '0) pend_err <= 1'b1;
               else                pend_cnt <= pend_cnt - PEND_W'(1);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         br_ready   <= 1'b1;
         res_valid  <= 1'b0;
         res_taken  <= 1'b0;
         res_target <= 16'h0000;
         ccc_q      <= 3'b000;
         pc_q       <= 16'h0000;
         imm_q      <= 9'h000;
         sel_q      <= 1'b0;
         rv_q       <= 16'h0000;
      end else begin
         case (state)
            IDLE: begin
               if (br_valid) begin
                  ccc_q    <= br_ccc;
                  pc_q     <= br_pc;
                  imm_q    <= br_imm;
                  sel_q    <= br_reg_sel;
                  rv_q     <= br_reg_val;
                  br_ready <= 1'b0;
                  state    <= WAIT;
               end
            end
            WAIT: begin
               if (resolve) begin
                  res_taken  <= taken_now;
                  res_target <= taken_now ? (sel_q ? rv_q : imm_target) : seq_pc;
                  res_valid  <= 1'b1;
                  state      <= RESP;
               end
            end
            RESP: begin
               res_valid <= 1'b0;
               br_ready  <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - vector, sequence and random checks for branch_resolve_unit
module tb_branch_resolve_unit;

   logic        clk, rst_n;
   logic [2:0]  flag_in;
   logic        flag_we_nv, flag_we_z, pend_inc;
   logic        pend_full, pend_err;
   logic [2:0]  flags_out;
   logic        br_valid, br_ready;
   logic [2:0]  br_ccc;
   logic [15:0] br_pc;
   logic [8:0]  br_imm;
   logic        br_reg_sel;
   logic [15:0] br_reg_val;
   logic        res_valid, res_taken;
   logic [15:0] res_target;

   int checks = 0;
   int errors = 0;
   logic [2:0] m_flags;

   branch_resolve_unit #(.PEND_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .flag_in(flag_in), .flag_we_nv(flag_we_nv),
      .flag_we_z(flag_we_z), .pend_inc(pend_inc), .pend_full(pend_full),
      .pend_err(pend_err), .flags_out(flags_out), .br_valid(br_valid),
      .br_ready(br_ready), .br_ccc(br_ccc), .br_pc(br_pc), .br_imm(br_imm),
      .br_reg_sel(br_reg_sel), .br_reg_val(br_reg_val), .res_valid(res_valid),
      .res_taken(res_taken), .res_target(res_target)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout actual running required finished");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic [2:0]  fl;
      logic [2:0]  ccc;
      logic [15:0] pc;
      logic [8:0]  imm;
      logic        sel;
      logic [15:0] rv;
      logic        tk;
      logic [15:0] tg;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h required %0h", name, act, exp);
      end
   endtask

   function automatic bit m_cond(input int ccc, input logic [2:0] f);
      bit n, v, z;
      n = f[2]; v = f[1]; z = f[0];
      case (ccc)
         0: return !z;
         1: return z;
         2: return !z && !n;
         3: return n;
         4: return !n || z;
         5: return n || z;
         6: return v;
         default: return 1;
      endcase
   endfunction

   function automatic int m_target(input bit tk, input bit sel, input int pc, input int imm, input int rv);
      int imm_s;
      if (!tk) return (pc + 2) % 65536;
      if (sel) return rv;
      imm_s = (imm > 255) ? imm - 512 : imm;
      return (((pc + 2 + 2 * imm_s) % 65536) + 65536) % 65536;
   endfunction

   task automatic idle_inputs();
      flag_in = 3'b000; flag_we_nv = 0; flag_we_z = 0; pend_inc = 0;
      br_valid = 0; br_ccc = 0; br_pc = 0; br_imm = 0; br_reg_sel = 0; br_reg_val = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      rst_n = 0;
      @(negedge clk);
      rst_n = 1;
      m_flags = 3'b000;
   endtask

   // Issue-then-retire pair keeps the pending count balanced at zero.
   task automatic set_flags(input logic [2:0] f);
      @(negedge clk);
      pend_inc = 1;
      @(negedge clk);
      pend_inc = 0; flag_we_nv = 1; flag_we_z = 1; flag_in = f;
      @(negedge clk);
      flag_we_nv = 0; flag_we_z = 0;
      m_flags = f;
   endtask

   task automatic wait_res(output int n);
      n = 1;
      while (!res_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!res_valid) chk("res_timeout", 0, 1);
   endtask

   task automatic run_branch(input logic [2:0] ccc, input logic [15:0] pc, input logic [8:0] imm,
                             input logic sel, input logic [15:0] rv,
                             output logic tk, output logic [15:0] tg, output int lat);
      @(negedge clk);
      chk("br_ready_idle", br_ready, 1);
      br_valid = 1; br_ccc = ccc; br_pc = pc; br_imm = imm; br_reg_sel = sel; br_reg_val = rv;
      @(negedge clk);
      br_valid = 0; br_ccc = ~ccc; br_pc = ~pc; br_imm = ~imm; br_reg_sel = ~sel; br_reg_val = ~rv;
      wait_res(lat);
      tk = res_taken; tg = res_target;
      chk("br_ready_resp", br_ready, 0);
      @(negedge clk);
      chk("res_valid_pulse", res_valid, 0);
      chk("br_ready_back", br_ready, 1);
      chk("res_hold", {res_taken, res_target}, {tk, tg});
   endtask

   initial begin
      logic        tk;
      logic [15:0] tg;
      int          lat, n;
      logic [2:0]  rf, rc;
      logic [15:0] rpc, rrv;
      logic [8:0]  rimm;
      logic        rsel;
      bit          etk;

      vecs[0]  = '{3'b001, 3'd1, 16'h0010, 9'h004, 1'b0, 16'h0000, 1'b1, 16'h001A};
      vecs[1]  = '{3'b100, 3'd2, 16'h0040, 9'h010, 1'b0, 16'h0000, 1'b0, 16'h0042};
      vecs[2]  = '{3'b100, 3'd2, 16'hFFFE, 9'h010, 1'b0, 16'h0000, 1'b0, 16'h0000};
      vecs[3]  = '{3'b000, 3'd7, 16'h0200, 9'h020, 1'b1, 16'h1234, 1'b1, 16'h1234};
      vecs[4]  = '{3'b000, 3'd7, 16'h0100, 9'h1FF, 1'b0, 16'h0000, 1'b1, 16'h0100};
      vecs[5]  = '{3'b010, 3'd6, 16'h2000, 9'h0FF, 1'b0, 16'h0000, 1'b1, 16'h2200};
      vecs[6]  = '{3'b000, 3'd0, 16'h0300, 9'h100, 1'b0, 16'h0000, 1'b1, 16'h0102};
      vecs[7]  = '{3'b001, 3'd0, 16'h0300, 9'h100, 1'b0, 16'h0000, 1'b0, 16'h0302};
      vecs[8]  = '{3'b100, 3'd3, 16'h1000, 9'h001, 1'b0, 16'h0000, 1'b1, 16'h1004};
      vecs[9]  = '{3'b001, 3'd4, 16'h0000, 9'h000, 1'b0, 16'h0000, 1'b1, 16'h0002};
      vecs[10] = '{3'b100, 3'd4, 16'h0000, 9'h000, 1'b0, 16'h0000, 1'b0, 16'h0002};
      vecs[11] = '{3'b000, 3'd5, 16'h8000, 9'h002, 1'b0, 16'h0000, 1'b0, 16'h8002};
      vecs[12] = '{3'b101, 3'd5, 16'h8000, 9'h002, 1'b0, 16'h0000, 1'b1, 16'h8006};
      vecs[13] = '{3'b000, 3'd2, 16'h7FFE, 9'h0FF, 1'b0, 16'h0000, 1'b1, 16'h81FE};
      vecs[14] = '{3'b000, 3'd6, 16'h7FFE, 9'h0FF, 1'b0, 16'h0000, 1'b0, 16'h8000};
      vecs[15] = '{3'b001, 3'd0, 16'h0010, 9'h004, 1'b1, 16'hBEEF, 1'b0, 16'h0012};

      idle_inputs();
      rst_n = 0;
      m_flags = 3'b000;
      #12;
      chk("rst_br_ready", br_ready, 1);
      chk("rst_res", {res_valid, res_taken, res_target}, 18'h0);
      chk("rst_flags", {flags_out, pend_full, pend_err}, 5'b0);
      @(negedge clk);
      rst_n = 1;

      for (int i = 0; i < 16; i++) begin
         set_flags(vecs[i].fl);
         run_branch(vecs[i].ccc, vecs[i].pc, vecs[i].imm, vecs[i].sel, vecs[i].rv, tk, tg, lat);
         chk($sformatf("vec%0d_taken", i), tk, vecs[i].tk);
         chk($sformatf("vec%0d_target", i), tg, vecs[i].tg);
         chk($sformatf("vec%0d_latency", i), lat, 2);
      end

      // Two older flag-setters outstanding; V arrives on the second retirement.
      set_flags(3'b000);
      @(negedge clk); pend_inc = 1;
      @(negedge clk);
      @(negedge clk);
      pend_inc = 0; br_valid = 1; br_ccc = 3'd6; br_pc = 16'h0500; br_imm = 9'h010; br_reg_sel = 0;
      @(negedge clk);
      br_valid = 0;
      chk("pend_wait_ready", br_ready, 0);
      chk("pend_wait_v0", res_valid, 0);
      @(negedge clk);
      chk("pend_wait_v1", res_valid, 0);
      flag_we_nv = 1; flag_in = 3'b010;
      @(negedge clk);
      flag_we_nv = 0;
      chk("pend_wait_v2", res_valid, 0);
      @(negedge clk);
      chk("pend_wait_v3", res_valid, 0);
      flag_we_nv = 1; flag_in = 3'b010;
      @(negedge clk);
      flag_we_nv = 0;
      wait_res(n);
`ifdef FLAG_BYPASS_EN
      chk("pend_latency", n, 1);
`else
      chk("pend_latency", n, 2);
`endif
      chk("pend_taken", res_taken, 1);
      chk("pend_target", res_target, 16'h0522);
      m_flags = 3'b010;
      chk("pend_flags", flags_out, m_flags);
      chk("pend_err_clean", {pend_full, pend_err}, 2'b00);
      @(negedge clk);
      chk("pend_ready_back", br_ready, 1);

      // A younger pend_inc during WAIT must not hold the branch.
      @(negedge clk);
      br_valid = 1; br_ccc = 3'd7; br_pc = 16'h0600; br_imm = 9'h001; br_reg_sel = 0;
      @(negedge clk);
      br_valid = 0; pend_inc = 1;
      @(negedge clk);
      pend_inc = 0;
      chk("young_inc_valid", res_valid, 1);
      chk("young_inc_target", res_target, 16'h0604);
      flag_we_nv = 1; flag_we_z = 1; flag_in = m_flags;
      @(negedge clk);
      flag_we_nv = 0; flag_we_z = 0;
      chk("young_inc_err", pend_err, 0);

      for (int i = 0; i < 40; i++) begin
         rf = 3'($urandom); rc = 3'($urandom); rpc = 16'($urandom);
         rimm = 9'($urandom); rsel = 1'($urandom); rrv = 16'($urandom);
         set_flags(rf);
         run_branch(rc, rpc, rimm, rsel, rrv, tk, tg, lat);
         etk = m_cond(int'(rc), m_flags);
         chk($sformatf("rnd%0d_taken", i), tk, etk);
         chk($sformatf("rnd%0d_target", i), tg, m_target(etk, rsel, int'(rpc), int'(rimm), int'(rrv)));
      end
      chk("rnd_err_clean", pend_err, 0);

      do_reset();
      @(negedge clk); pend_inc = 1;
      repeat (3) @(negedge clk);
      chk("full_at3", pend_full, 1);
      chk("err_before_ovf", pend_err, 0);
      @(negedge clk);
      pend_inc = 0;
      chk("full_hold", pend_full, 1);
      chk("err_ovf", pend_err, 1);
      flag_we_z = 1; flag_in = 3'b000;
      @(negedge clk);
      chk("full_drop", pend_full, 0);
      repeat (2) @(negedge clk);
      flag_we_z = 0;
      chk("err_sticky", pend_err, 1);
      do_reset();
      chk("err_cleared", pend_err, 0);
      flag_we_z = 1; flag_in = 3'b001;
      @(negedge clk);
      flag_we_z = 0;
      m_flags = 3'b001;
      chk("err_underflow", pend_err, 1);
      chk("underflow_flags", flags_out, m_flags);

      // Asynchronous reset while the branch is waiting on an older writer.
      @(negedge clk); pend_inc = 1;
      @(negedge clk);
      pend_inc = 0; br_valid = 1; br_ccc = 3'd7; br_pc = 16'h0700; br_imm = 9'h002;
      @(negedge clk);
      br_valid = 0;
      chk("midwait_ready", br_ready, 0);
      #2 rst_n = 0;
      #1;
      chk("midrst_ready", br_ready, 1);
      chk("midrst_res", {res_valid, res_taken, res_target}, 18'h0);
      chk("midrst_flags", {flags_out, pend_full, pend_err}, 5'b0);
      @(negedge clk);
      rst_n = 1;
      m_flags = 3'b000;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("midrst_no_valid", res_valid, 0);
      end
      run_branch(3'd7, 16'h0700, 9'h002, 1'b0, 16'h0000, tk, tg, lat);
      chk("post_rst_taken", tk, 1);
      chk("post_rst_target", tg, 16'h0706);
      chk("post_rst_latency", lat, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
